seg_req_arbiter: RTL and testbench

// - Arbitrates eight requesters (board switches or upstream logic) for one shared 7-seg digit.
// - Grants one requester at a time and holds the grant for HOLD_CYCLES clocks.
// - Drives the granted index as a 3-bit code and one-hot vector, and shows it as a decimal digit.
// - Sequential successor to the combinational 8-to-3 priority encoder and digit decoder.

---
 rtl/seg_req_arbiter_if.sv | 30 +++
 rtl/seg_req_arbiter.sv | 133 +++++++++++++
 tb/tb_seg_req_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seg_req_arbiter_if.sv
// Request/grant bundle between eight requesters and the shared 7-seg digit arbiter.
// Latency: none (wires only).
// Backpressure: none; requests are level-held by the requesters until served or withdrawn.
//
// Signals:
//   req          8  request vector, bit i = requester i
//   grant_valid  1  a grant is active
//   grant_idx    3  granted requester index (0 when idle)
//   grant_oh     8  one-hot grant (8'h00 when idle)
//   grant_new    1  pulse on the first cycle of every grant
//   seg          7  {a,b,c,d,e,f,g} active-low digit of grant_idx, 7'h7F when idle
// Modports: master = requester side, slave = arbiter side.
interface seg_req_arbiter_if;
  logic [7:0] req;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_oh;
  logic       grant_new;
  logic [6:0] seg;

  modport master (
    output req,
    input  grant_valid, grant_idx, grant_oh, grant_new, seg
  );

  modport slave (
    input  req,
    output grant_valid, grant_idx, grant_oh, grant_new, seg
  );
endinterface

// File: rtl/seg_req_arbiter.sv
// Arbitrates eight level requests for one shared 7-seg digit, holding each grant HOLD_CYCLES clocks.
// Latency: 1 clk from req to registered grant; seg follows the grant combinationally.
// Backpressure: none; other requesters simply wait until the next arbitration point.
//
// Ports: clk, rst (synchronous, active-high), bus (seg_req_arbiter_if.slave: req in;
//        grant_valid/grant_idx/grant_oh/grant_new/seg out).
// Build option: define SEG_RR_ARB_EN for round-robin starting at ptr; otherwise the
//        highest set request index wins and ptr is tracked but not used for selection.
module seg_req_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 32
) (
  input logic              clk,
  input logic              rst,
  seg_req_arbiter_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       ptr;
  logic             grant_valid_q;
  logic [2:0]       grant_idx_q;
  logic [7:0]       grant_oh_q;
  logic             grant_new_q;

  logic             arb;
  logic             win_vld;
  logic [2:0]       win_idx;

  // Arbitrate when idle with any request, or when the dwell expires or the
  // holder withdraws its request.
  always_comb begin
    arb = 1'b0;
    if (state == IDLE) begin
      arb = |bus.req;
    end else begin
      arb = (cnt == '0) || !bus.req[grant_idx_q];
    end
  end

`ifdef SEG_RR_ARB_EN
  logic [2:0] cand;

  // Scan offsets from far to near so the set bit closest to ptr (ascending,
  // wrapping 7->0) is the last assignment and therefore the winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 3'd0;
    cand    = ptr;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end
`else
  // Fixed priority: ascending scan, so the highest set index is assigned last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (bus.req[k]) begin
        win_vld = 1'b1;
        win_idx = 3'(k);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      ptr           <= 3'd0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= 3'd0;
      grant_oh_q    <= 8'h00;
      grant_new_q   <= 1'b0;
    end else begin
      grant_new_q <= 1'b0;
      if (arb) begin
        if (win_vld) begin
          state         <= HOLD;
          cnt           <= CNT_W'(HOLD_CYCLES - 1);
          ptr           <= win_idx + 3'd1;
          grant_valid_q <= 1'b1;
          grant_idx_q   <= win_idx;
          grant_oh_q    <= 8'h01 << win_idx;
          grant_new_q   <= 1'b1;
        end else begin
          state         <= IDLE;
          grant_valid_q <= 1'b0;
          grant_idx_q   <= 3'd0;
          grant_oh_q    <= 8'h00;
        end
      end else if (state == HOLD) begin
        // cnt is nonzero here, otherwise arb would have fired.
        cnt <= cnt - 1'b1;
      end
    end
  end

  // While holding, ptr always points one past the current holder.
  ptr_tracks_holder: assert property (@(posedge clk) disable iff (rst)
    (state == HOLD) |-> (ptr == grant_idx_q + 3'd1));

  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_oh    = grant_oh_q;
  assign bus.grant_new   = grant_new_q;

  // Active-low {a,b,c,d,e,f,g}; blank when no grant.
  always_comb begin
    bus.seg = 7'h7F;
    if (grant_valid_q) begin
      case (grant_idx_q)
        3'd0:    bus.seg = 7'h01;
        3'd1:    bus.seg = 7'h4F;
        3'd2:    bus.seg = 7'h12;
        3'd3:    bus.seg = 7'h06;
        3'd4:    bus.seg = 7'h4C;
        3'd5:    bus.seg = 7'h24;
        3'd6:    bus.seg = 7'h20;
        default: bus.seg = 7'h0F;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_req_arbiter.sv
// Directed bench for seg_req_arbiter with HOLD_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
module tb_seg_req_arbiter;

`ifdef SEG_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seg_req_arbiter_if bus ();

  seg_req_arbiter #(
    .HOLD_CYCLES(4),
    .CNT_W      (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [6:0] seg_of(input logic v, input logic [2:0] idx);
    logic [6:0] t [8];
    t = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F};
    return v ? t[idx] : 7'h7F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic v, input logic [2:0] idx, input logic nw);
    logic [7:0] oh;
    oh = v ? (8'h01 << idx) : 8'h00;
    chk({tag, ".valid"}, 32'(bus.grant_valid), 32'(v));
    chk({tag, ".idx"},   32'(bus.grant_idx),   32'(v ? idx : 3'd0));
    chk({tag, ".oh"},    32'(bus.grant_oh),    32'(oh));
    chk({tag, ".new"},   32'(bus.grant_new),   32'(nw));
    chk({tag, ".seg"},   32'(bus.seg),         32'(seg_of(v, idx)));
  endtask

  initial begin
    rst     = 1'b1;
    bus.req = 8'hFF;

    // Reset held two clocks with every request asserted.
    tick(); chk_grant("rst0", 1'b0, 3'd0, 1'b0);
    tick(); chk_grant("rst1", 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    // First grant one clock after reset falls: RR from ptr=0 picks 0, fixed picks 7.
    tick(); chk_grant("first", 1'b1, RR ? 3'd0 : 3'd7, 1'b1);
    bus.req = 8'h00;
    tick(); chk_grant("drain0", 1'b0, 3'd0, 1'b0);

    // Single steady requester: re-grant every 4 clocks, valid never drops.
    bus.req = 8'h04;
    for (int i = 0; i < 9; i++) begin
      tick(); chk_grant($sformatf("single%0d", i), 1'b1, 3'd2, (i % 4) == 0);
    end
    bus.req = 8'h00;
    tick(); chk_grant("drain1", 1'b0, 3'd0, 1'b0);

    // Two requesters 0 and 7. ptr is 3 after the idx-2 grants, so RR starts with 7.
    bus.req = 8'h81;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_grant($sformatf("two%0d", i), 1'b1,
                RR ? (((i / 4) % 2 == 0) ? 3'd7 : 3'd0) : 3'd7, (i % 4) == 0);
    end

    // Holder 7 withdraws; RR wraps ptr 7->0 so 0 then 1, fixed gives 1 throughout.
    bus.req = 8'h03;
    tick(); chk_grant("wrap0", 1'b1, RR ? 3'd0 : 3'd1, 1'b1);
    tick(); chk_grant("wrap1", 1'b1, RR ? 3'd0 : 3'd1, 1'b0);
    tick(); tick();
    tick(); chk_grant("wrap4", 1'b1, 3'd1, 1'b1);
    bus.req = 8'h00;
    tick(); chk_grant("drain2", 1'b0, 3'd0, 1'b0);

    // Early release to idle.
    bus.req = 8'h08;
    tick(); chk_grant("rel_a0", 1'b1, 3'd3, 1'b1);
    tick(); chk_grant("rel_a1", 1'b1, 3'd3, 1'b0);
    bus.req = 8'h00;
    tick(); chk_grant("rel_a2", 1'b0, 3'd0, 1'b0);

    // Early release handing over to requester 5.
    bus.req = 8'h08;
    tick(); chk_grant("rel_b0", 1'b1, 3'd3, 1'b1);
    tick(); chk_grant("rel_b1", 1'b1, 3'd3, 1'b0);
    bus.req = 8'h20;
    tick(); chk_grant("rel_b2", 1'b1, 3'd5, 1'b1);
    bus.req = 8'h00;
    tick(); chk_grant("drain3", 1'b0, 3'd0, 1'b0);

    // Reset in the middle of a grant, then re-grant with a full dwell.
    bus.req = 8'h10;
    tick(); chk_grant("mid0", 1'b1, 3'd4, 1'b1);
    tick(); chk_grant("mid1", 1'b1, 3'd4, 1'b0);
    rst = 1'b1;
    tick(); chk_grant("mid_rst", 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_grant($sformatf("mid_after%0d", i), 1'b1, 3'd4, (i % 4) == 0);
    end
    bus.req = 8'h00;
    tick(); chk_grant("drain4", 1'b0, 3'd0, 1'b0);

    // Idle with no requests stays idle.
    tick(); chk_grant("idle", 1'b0, 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
